// File: rtl/fft_frame_stream.sv
// rtl/fft_frame_stream.sv - serial sample stream to/from a flat-bus fft core
//
// Collects LEN serial samples into the flat fft input bus. It then holds
// fft_enable for FFT_LAT cycles and snapshots the fft output bus. Finally it
// drains that snapshot as LEN serial samples.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     input sample stream
//   fft_d, fft_enable             packed frame and enable to the fft core
//   fft_dataout                   packed fft result (sample j at [W*j +: W])
//   out_valid/out_ready/out_data  output sample stream
//   out_last                      marks sample LEN-1 of each frame
//   frame_cnt                     count of fully drained frames (wraps)
module fft_frame_stream #(
    parameter int LEN     = 8,
    parameter int W       = 32,
    parameter int FFT_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [LEN*W-1:0] fft_d,
    output logic             fft_enable,
    input  logic [LEN*W-1:0] fft_dataout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [15:0]      frame_cnt
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FFT_LAT - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [LEN*W-1:0]  cap_buf;
    logic [IW-1:0]     idx_nxt;

    assign idx_nxt  = idx + IW'(1);
    assign in_ready = (state == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            cnt        <= '0;
            fft_d      <= '0;
            fft_enable <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_cnt  <= '0;
            cap_buf    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        // Slots not written this frame keep the previous frame's samples.
                        fft_d[W*idx +: W] <= in_data;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            cnt        <= '0;
                            fft_enable <= 1'b1;
                            state      <= RUN;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end

                RUN: begin
                    if (cnt == CNT_LAST) begin
                        // Single sampling point: later fft_dataout changes are ignored.
                        cap_buf    <= fft_dataout;
                        fft_enable <= 1'b0;
                        out_valid  <= 1'b1;
                        out_data   <= fft_dataout[W-1:0];
                        out_last   <= (LEN == 1);
                        state      <= DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= LOAD;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= cap_buf[W*idx_nxt +: W];
                            out_last <= (idx_nxt == IDX_LAST);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule
